// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// parity mode constants and the bit-timer width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Width of a down-counter that must hold CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side bundle: serial line in, parallel word plus status strobes out.
// The slave modport is the receiver; the master modport is the line driver / word consumer.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] dataout;
    logic                 done;
    logic                 tick;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx,
        input  dataout,
        input  done,
        input  tick,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx,
        output dataout,
        output done,
        output tick,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter pacing the receiver's sample points; expire_o flags
// a zero count and tick_o is a registered strobe for every enabled expiry.
module uart_bit_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o,
    output logic             tick_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // Counter only reaches zero and waits there; it wraps solely through a reload.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
        tick_d = en_i && (count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign expire_o = (count_q == '0);
    assign tick_o   = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver (start / DATA_BITS / optional parity / STOP_BITS).
// Define UART_RX_PARITY_EN to build the parity state and parity_err logic.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_MODE  = 0
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.slave  bus
);

    localparam int BCNT_W = 4;
    localparam int CNT_W  = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    // Without the parity hardware the mode collapses to "none".
`ifdef UART_RX_PARITY_EN
    localparam int PAR_MODE_EFF = PARITY_MODE;
`else
    localparam int PAR_MODE_EFF = PARITY_MODE * 0;
`endif
    localparam bit PAR_ON = (PAR_MODE_EFF != PARITY_NONE);

    rx_state_e            state_q;
    logic [BCNT_W-1:0]    bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dataout_q;
    logic                 done_q;
    logic                 frame_err_q;
    logic                 ferr_acc_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_q;
    logic                 perr_acc_q;
`endif

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic start_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_sync_q;

    logic             timer_en;
    logic             timer_load;
    logic             timer_expire;
    logic             timer_tick;
    logic [CNT_W-1:0] timer_load_val;

    // Half a bit from the start edge lands on mid-bit; every later sample is a full bit on.
    always_comb begin
        timer_en       = (state_q != IDLE);
        timer_load     = timer_en ? timer_expire : start_edge;
        timer_load_val = timer_en ? FULL_LOAD : HALF_LOAD;
    end

    uart_bit_timer #(
        .WIDTH (CNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (timer_en),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .expire_o   (timer_expire),
        .tick_o     (timer_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            dataout_q    <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            ferr_acc_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            perr_acc_q   <= 1'b0;
`endif
        end else begin
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q    <= START;
                        bit_cnt_q  <= '0;
                        ferr_acc_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_acc_q <= 1'b0;
`endif
                    end
                end
                START: begin
                    // A line that is high again at mid-start was a glitch.
                    if (timer_expire) begin
                        state_q <= rx_sync_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (timer_expire) begin
                        shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BCNT_W'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= PAR_ON ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer_expire) begin
                        perr_acc_q <= (^shift_q) ^ rx_sync_q ^ (PAR_MODE_EFF == PARITY_ODD);
                        state_q    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (timer_expire) begin
                        if (bit_cnt_q == BCNT_W'(STOP_BITS - 1)) begin
                            done_q       <= 1'b1;
                            dataout_q    <= shift_q;
                            frame_err_q  <= ferr_acc_q | ~rx_sync_q;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= perr_acc_q;
`endif
                            state_q      <= IDLE;
                        end else begin
                            ferr_acc_q <= ferr_acc_q | ~rx_sync_q;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dataout   = dataout_q;
    assign bus.done      = done_q;
    assign bus.tick      = timer_tick;
    assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 receiver and a 2-stop-bit (even parity
// when UART_RX_PARITY_EN is defined) receiver share clock and reset.
`timescale 1ns/1ps
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int CPB = 20;
`ifdef UART_RX_PARITY_EN
    localparam int P1 = 1;
`else
    localparam int P1 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(8)) if0 ();
    uart_rx_core_if #(.DATA_BITS(8)) if1 ();

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PARITY_MODE  (PARITY_NONE)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (2),
        .PARITY_MODE  (PARITY_EVEN)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int flag_viol = 0;
    int done_cnt [2] = '{default: 0};
    int tick_cnt [2] = '{default: 0};
    int last_cyc [2] = '{default: 0};
    logic [7:0] last_data [2] = '{default: 8'h00};
    logic       last_ferr [2] = '{default: 1'b0};
    logic       last_perr [2] = '{default: 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor; records every done strobe and counts sample ticks.
    always @(negedge clk) begin
        if (if0.done) begin
            done_cnt[0]  <= done_cnt[0] + 1;
            last_cyc[0]  <= cyc;
            last_data[0] <= if0.dataout;
            last_ferr[0] <= if0.frame_err;
            last_perr[0] <= if0.parity_err;
        end
        if (if1.done) begin
            done_cnt[1]  <= done_cnt[1] + 1;
            last_cyc[1]  <= cyc;
            last_data[1] <= if1.dataout;
            last_ferr[1] <= if1.frame_err;
            last_perr[1] <= if1.parity_err;
        end
        if (if0.tick) tick_cnt[0] <= tick_cnt[0] + 1;
        if (if1.tick) tick_cnt[1] <= tick_cnt[1] + 1;
        if ((!if0.done && (if0.frame_err || if0.parity_err)) ||
            (!if1.done && (if1.frame_err || if1.parity_err)))
            flag_viol <= flag_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v);
        if (d == 0) if0.rx = v;
        else        if1.rx = v;
    endtask

    task automatic hold(input int d, input logic v, input int n);
        drive(d, v);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; start_c is the posedge that first samples the start bit.
    task automatic send_frame(input int d, input logic [7:0] data, input bit use_par,
                              input logic par_bit, input int nstop, input logic stop_val,
                              output int start_c);
        start_c = cyc + 1;
        hold(d, 1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d, data[i], CPB);
        if (use_par) hold(d, par_bit, CPB);
        for (int i = 0; i < nstop; i++) hold(d, stop_val, CPB);
    endtask

    task automatic check_frame(input string tag, input int d, input int dc_before,
                               input logic [7:0] ed, input logic ef, input logic ep,
                               input int s, input int elat);
        chk({tag, "_count"}, done_cnt[d] - dc_before, 1);
        chk({tag, "_data"},  last_data[d], ed);
        chk({tag, "_ferr"},  last_ferr[d], ef);
        chk({tag, "_perr"},  last_perr[d], ep);
        chk({tag, "_lat"},   last_cyc[d] - s, elat);
        $display("frame %s dut%0d data=%02h ferr=%b perr=%b lat=%0d",
                 tag, d, last_data[d], last_ferr[d], last_perr[d], last_cyc[d] - s);
    endtask

    initial begin
        int s0, s1, s2, dc, tc, first_cyc;
        logic [7:0] first_data;
        logic [7:0] part;

        if0.rx = 1'b1;
        if1.rx = 1'b1;
        rst    = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_dataout0", if0.dataout, 8'h00);
        chk("rst_done0",    if0.done, 1'b0);
        chk("rst_tick0",    if0.tick, 1'b0);
        chk("rst_ferr0",    if0.frame_err, 1'b0);
        chk("rst_perr0",    if0.parity_err, 1'b0);
        chk("rst_dataout1", if1.dataout, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Nominal 8N1: 2 + 10 + 9*20 = 192 cycles.
        dc = done_cnt[0];
        tc = tick_cnt[0];
        send_frame(0, 8'b10010101, 1'b0, 1'b0, 1, 1'b1, s0);
        repeat (10) @(negedge clk);
        check_frame("nominal", 0, dc, 8'h95, 1'b0, 1'b0, s0, 192);
        chk("nominal_ticks", tick_cnt[0] - tc, 10);

        // Glitch: 5 low cycles gives only the start sample tick, no done.
        dc = done_cnt[0];
        tc = tick_cnt[0];
        hold(0, 1'b0, 5);
        hold(0, 1'b1, 40);
        chk("glitch_no_done", done_cnt[0] - dc, 0);
        chk("glitch_ticks",   tick_cnt[0] - tc, 1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, s0);
        repeat (10) @(negedge clk);
        check_frame("after_glitch", 0, dc, 8'h3C, 1'b0, 1'b0, s0, 192);

        // Framing error, then the line stays low: no new frame may start.
        dc = done_cnt[0];
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, s0);
        repeat (5) @(negedge clk);
        check_frame("frame_err", 0, dc, 8'hA5, 1'b1, 1'b0, s0, 192);
        dc = done_cnt[0];
        tc = tick_cnt[0];
        hold(0, 1'b0, 60);
        chk("low_hold_no_done", done_cnt[0] - dc, 0);
        chk("low_hold_no_tick", tick_cnt[0] - tc, 0);
        hold(0, 1'b1, 30);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, s0);
        repeat (10) @(negedge clk);
        check_frame("after_ferr", 0, dc, 8'h11, 1'b0, 1'b0, s0, 192);

        // Back-to-back on the 2-stop receiver.
        dc = done_cnt[1];
        send_frame(1, 8'h00, P1 != 0, 1'b0, 2, 1'b1, s1);
        first_cyc  = last_cyc[1];
        first_data = last_data[1];
        send_frame(1, 8'hFF, P1 != 0, 1'b0, 2, 1'b1, s2);
        repeat (10) @(negedge clk);
        chk("b2b_count",      done_cnt[1] - dc, 2);
        chk("b2b_first_data", first_data, 8'h00);
        chk("b2b_first_lat",  first_cyc - s1, 12 + (10 + P1) * CPB);
        chk("b2b_gap",        last_cyc[1] - first_cyc, (11 + P1) * CPB);
        check_frame("b2b_second", 1, dc + 1, 8'hFF, 1'b0, 1'b0, s2, 12 + (10 + P1) * CPB);

`ifdef UART_RX_PARITY_EN
        // Even parity: 8'hA5 has four ones, so a parity bit of 1 is wrong.
        hold(1, 1'b1, 10);
        dc = done_cnt[1];
        send_frame(1, 8'hA5, 1'b1, 1'b1, 2, 1'b1, s1);
        repeat (10) @(negedge clk);
        check_frame("par_bad", 1, dc, 8'hA5, 1'b0, 1'b1, s1, 232);
        dc = done_cnt[1];
        send_frame(1, 8'hA5, 1'b1, 1'b0, 2, 1'b1, s1);
        repeat (10) @(negedge clk);
        check_frame("par_good", 1, dc, 8'hA5, 1'b0, 1'b0, s1, 232);
`endif

        // Reset right after data bit 3 has been sampled.
        dc   = done_cnt[0];
        part = 8'hC3;
        hold(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(0, part[i], CPB);
        if0.rx = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dataout", if0.dataout, 8'h00);
        chk("midrst_tick",    if0.tick, 1'b0);
        tc = tick_cnt[0];
        repeat (40) @(negedge clk);
        chk("midrst_no_done",  done_cnt[0] - dc, 0);
        chk("midrst_no_tick",  tick_cnt[0] - tc, 0);
        chk("midrst_dataout1", if1.dataout, 8'h00);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1, s0);
        repeat (10) @(negedge clk);
        check_frame("after_rst", 0, dc, 8'h5A, 1'b0, 1'b0, s0, 192);

        chk("flags_only_with_done", flag_viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver; next generation of the fixed 8N1 receive FSM. Converts the asynchronous serial `rx` line into parallel words with configurable clocks-per-bit, data width, stop bits and optional parity, and reports framing and parity errors. Sits between the pad-side `rx` pin and the byte consumer; output is a one-cycle `done` strobe qualifying `dataout`.

## Interface
- `CLKS_PER_BIT`, 20, clock cycles per bit period; legal range 4 or greater.
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `STOP_BITS`, 1, stop bits checked; 1 or 2.
- `PARITY_MODE`, 0, 0 = none, 1 = even, 2 = odd. Only honoured with `UART_RX_PARITY_EN`.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idle high, LSB first.
- `dataout` out DATA_BITS: last received word; held until the next `done`.
- `done` out 1: one-cycle strobe when a frame completes.
- `tick` out 1: one-cycle pulse at every mid-bit sample point, including start, data, parity and stop.
- `frame_err` out 1: valid with `done`; a stop bit was sampled low.
- `parity_err` out 1: valid with `done`; parity mismatch.

## Operation
- `rx` passes through a 2-flop synchroniser. The synchroniser flops reset to 1.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - Enter START on a falling edge of synced `rx` (previous 1, current 0).
  - Load the bit counter with `CLKS_PER_BIT/2 - 1`.
- **START:**
  - At counter expiry, sample `rx`.
  - If `rx` = 1, it was a glitch: return to IDLE with no `done`.
  - Otherwise go to DATA and reload the counter with `CLKS_PER_BIT - 1`.
- **DATA:**
  - Sample every `CLKS_PER_BIT` cycles into a shift register, LSB first.
  - After `DATA_BITS` samples, go to PARITY if parity is enabled and mode is not 0; otherwise go to STOP.
- **PARITY:**
  - Take one sample.
  - Compute `parity_err` = XOR of the data and the parity bit, XOR 1 if odd mode.
- **STOP:**
  - Take `STOP_BITS` samples.
  - If any sample is 0, `frame_err` = 1.
  - On the final stop sample: pulse `done`, load `dataout`, drive both error flags, and return to IDLE.
- Frames with errors still deliver `dataout` and `done`.
- After a frame error (line held low), no new frame starts until synced `rx` returns high, because start detection requires a 1→0 edge.
- `tick` is asserted in the same cycle as each sample.
- The counter width is `$clog2(CLKS_PER_BIT)`. Counters wrap only by reload, never by overflow.

## Timing
- **Reset values:**
  - state = IDLE; `dataout` = 0; `done`, `tick`, `frame_err` and `parity_err` = 0.
  - Synchroniser flops = 1.
- **Reset mid-frame:** abort immediately. No `done` is issued, and the shift register is cleared.
- **Latency:** `done` asserts exactly 2 + `CLKS_PER_BIT/2` + (`DATA_BITS` + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles after the first rising edge at which `rx` is sampled low. P = 1 when parity is active, otherwise 0.
- **Output hold:** `done`, `frame_err` and `parity_err` are high for exactly one cycle. The error flags are 0 whenever `done` is 0.
- **Back-to-back frames:** a start edge arriving directly after the final stop sample is accepted. IDLE can detect a start edge in the cycle after `done`.
- There is no backpressure. If the consumer misses `done`, the word is overwritten by the next frame.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the PARITY state and `parity_err` logic are built, and `PARITY_MODE` is honoured.
- **Undefined:** the PARITY state is omitted, `PARITY_MODE` is ignored (treated as 0), and `parity_err` is tied to 0.

## Structure
- **Shared package `uart_pkg`:**
  - State enumeration: IDLE, START, DATA, PARITY, STOP.
  - `PARITY_NONE`/`EVEN`/`ODD` constants.
  - Helper function for counter width.
- **One sub-module, `uart_bit_timer`:**
  - Loadable down-counter.
  - Load value input and `expire` output.
  - Drives the `tick` sample strobe.

## Test plan
- **Nominal 8N1:** `CLKS_PER_BIT`=20, 8N1, send 8'b10010101 → single `done`; `dataout`=8'h95; both error flags 0; latency 192 cycles.
- **Glitch rejection:** `rx` low for 5 cycles, then high → no `done`; state back to IDLE; the next frame 8'h3C is received correctly.
- **Framing error:** send 8'hA5 with the stop bit driven 0 → `done` with `dataout`=8'hA5 and `frame_err`=1. The next frame 8'h11 is not started until `rx` returns high.
- **Parity:** with `UART_RX_PARITY_EN`, even mode, send 8'hA5 with parity bit 1 → `parity_err`=1. Repeat with parity bit 0 → `parity_err`=0.
- **Back-to-back and 2 stop bits:** `STOP_BITS`=2, send 8'h00 then 8'hFF back-to-back → two `done` pulses, 11×20 cycles apart; correct data for each.
- **Reset mid-frame:** assert `rst` for one cycle after data bit 3 → no `done`; outputs at reset values. A subsequent frame 8'h5A is received correctly.
